mogu_collide: RTL and testbench
===============================

Name: mogu_collide

Overview:
- Consumer side of the enemy-controller interface: takes the spawn mask MOGU and the enemy positions C1..C4 / R1..R4, plus Mario's box.
- Produces the alive mask MM that the enemy controller uses to gate movement.
- Once per frame tick: detects Mario/enemy overlap, classifies each overlap as a stomp (kills the enemy) or a hit (hurts Mario), and runs the squash animation and score.
- Sits between the enemy controller and the game FSM / renderer.

Parameters:
- MW, 16, enemy width in pixels
- MH, 16, enemy height in pixels
- PW, 16, Mario width in pixels
- PH, 16, Mario height in pixels
- STOMP_TOL, 4, maximum pixels Mario's bottom edge may sit below the enemy top and still count as a stomp
- SQUASH_FRAMES, 8, number of ticks a killed enemy shows as squashed
- INV_FRAMES, 60, number of ticks of invincibility after a hit
- SCORE_STEP, 100, points added per stomp

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tick  in  1  frame strobe, one clk wide
- MOGU  in  4  spawn mask; a 0->1 edge on bit i spawns enemy i
- C1..C4  in  11 each  enemy column (x)
- R1..R4  in  11 each  enemy row (y)
- mx  in  11  Mario x
- my  in  11  Mario y
- falling  in  1  Mario vertical velocity is downward
- MM  out  4  alive mask; bit i is 1 while enemy i is alive and moving
- SQ  out  4  squash mask, drives the squashed sprite
- stomp  out  1  one-cycle pulse: at least one kill this frame
- hurt  out  1  one-cycle pulse: Mario was hit
- inv  out  1  Mario is invincible
- score  out  16  saturating score

Behaviour:
- Reset (async, rst_n=0): MM=0, SQ=0, score=0, stomp=0, hurt=0, inv=0, all squash/inv counters 0, registered copy of MOGU=0, FSM=IDLE.
- Reset asserted mid-scan aborts the scan; no pulses follow.
- Spawn: evaluated every clk. Rising edge of MOGU[i] sets MM[i]=1 and clears SQ[i] and squash counter i, even if enemy i was squashing. A spawn edge beats a kill committed in the same cycle.
- FSM states: IDLE -> SCAN (idx 0..3, one enemy per clk) -> COMMIT -> IDLE.
  - tick in IDLE enters SCAN with idx=0.
  - A tick arriving in SCAN or COMMIT is ignored.
  - Positions must be held stable from tick to COMMIT.
- Latency: tick at cycle T; SCAN runs T+1..T+4; COMMIT at T+5. MM, SQ, score and inv update in T+5. stomp/hurt are high in T+5 only.
- Overlap test for enemy i: only when MM[i]=1.
  - mx < Ci+MW and Ci < mx+PW and my < Ri+MH and Ri < my+PH.
  - All sums computed 12 bits wide, so there is no wrap.
- Classification of an overlapping enemy:
  - Stomp: falling=1 and my+PH <= Ri+STOMP_TOL. Sets a kill flag for i.
  - Otherwise: sets the frame hit flag.
- COMMIT:
  - Each killed i: MM[i]=0, SQ[i]=1, squash counter = SQUASH_FRAMES.
  - score += SCORE_STEP × kill count, saturating at 16'hFFFF.
  - stomp = any kill.
  - hurt = hit flag & ~any kill & ~inv. Any stomp in a frame cancels that frame's hits (bounce).
  - hurt sets the inv counter to INV_FRAMES.
- Per tick in COMMIT:
  - Each nonzero squash counter decrements; when it reaches 0, SQ[i] clears.
  - Nonzero inv counter decrements; inv = (inv counter != 0).
- Squashed enemies (MM=0) are never collidable.

Optional Feature:
- Macro STAR_MODE_EN.
  - Defined: adds input star (1 bit). While star=1, every overlap with an alive enemy is a kill regardless of falling or height, hurt is never asserted, and inv is unaffected.
  - Undefined: the star port is absent and classification is exactly as above.

Test Plan:
- Reset, then MOGU 0000->0001 -> MM=0001 next clk; SQ=0000; score=0.
- Stomp: enemy 0 at C1=100, R1=144; Mario mx=104, my=130, falling=1; tick at T -> at T+5 MM=0000, SQ=0001, stomp=1 for one clk, score=100; SQ clears after 8 further ticks.
- Side hit: same enemy; mx=90, my=144, falling=0; tick -> hurt=1 at T+5, inv=1, MM unchanged. A repeat overlap on the next 59 ticks gives no hurt; the overlap on tick 61 gives hurt again.
- Mixed frame: enemy 0 stomped and enemy 1 side-overlapping in the same tick -> stomp=1, hurt=0, score +100, MM bit1 stays 1.
- Double stomp: enemies 0 and 1 both stompable in one tick -> MM=0000, score +200. With score preset near 16'hFFC0, score saturates at 16'hFFFF.
- Tick repeated at T+2 is ignored, giving only one COMMIT. rst_n pulsed low at T+3 -> no stomp/hurt, all outputs back to reset values.

Source files
------------

// File: rtl/mogu_collide.sv
// mogu_collide: Mario / enemy collision resolver.
// Tracks which of the four enemies are alive from the MOGU spawn mask.
// On each frame tick it scans the enemies one per clock, classifies any
// overlap with Mario as a stomp (enemy dies) or a hit (Mario is hurt),
// then commits kills, squash animation, score and invincibility.
// Optional feature macro: STAR_MODE_EN (adds the 'star' input; while it
// is high every overlap kills the enemy and Mario is never hurt).
module mogu_collide #(
    parameter int unsigned MW            = 16,
    parameter int unsigned MH            = 16,
    parameter int unsigned PW            = 16,
    parameter int unsigned PH            = 16,
    parameter int unsigned STOMP_TOL     = 4,
    parameter int unsigned SQUASH_FRAMES = 8,
    parameter int unsigned INV_FRAMES    = 60,
    parameter int unsigned SCORE_STEP    = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic [3:0]  MOGU,
    input  logic [10:0] C1,
    input  logic [10:0] C2,
    input  logic [10:0] C3,
    input  logic [10:0] C4,
    input  logic [10:0] R1,
    input  logic [10:0] R2,
    input  logic [10:0] R3,
    input  logic [10:0] R4,
    input  logic [10:0] mx,
    input  logic [10:0] my,
    input  logic        falling,
`ifdef STAR_MODE_EN
    input  logic        star,
`endif
    output logic [3:0]  MM,
    output logic [3:0]  SQ,
    output logic        stomp,
    output logic        hurt,
    output logic        inv,
    output logic [15:0] score
);

    localparam int SQW = $clog2(SQUASH_FRAMES + 1);
    localparam int IVW = $clog2(INV_FRAMES + 1);

    localparam logic [11:0]    MW12  = 12'(MW);
    localparam logic [11:0]    MH12  = 12'(MH);
    localparam logic [11:0]    PW12  = 12'(PW);
    localparam logic [11:0]    PH12  = 12'(PH);
    localparam logic [11:0]    TOL12 = 12'(STOMP_TOL);
    localparam logic [SQW-1:0] SQ_LOAD  = SQW'(SQUASH_FRAMES);
    localparam logic [SQW-1:0] SQ_ONE   = SQW'(1);
    localparam logic [SQW-1:0] SQ_ZERO  = {SQW{1'b0}};
    localparam logic [IVW-1:0] INV_LOAD = IVW'(INV_FRAMES);
    localparam logic [IVW-1:0] INV_ONE  = IVW'(1);
    localparam logic [IVW-1:0] INV_ZERO = {IVW{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // Number of set bits in a 4-bit kill mask.
    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    state_t                  state_r, state_s;
    logic [1:0]              idx_r;
    logic [3:0]              kill_r;
    logic                    hit_r;
    logic [3:0]              mogu_r;
    logic [3:0]              mm_r, mm_nxt_s;
    logic [3:0]              sq_r, sq_nxt_s;
    logic [3:0][SQW-1:0]     sq_cnt_r, sq_cnt_nxt_s;
    logic [IVW-1:0]          inv_cnt_r, inv_dec_s, inv_nxt_s;
    logic                    inv_r, stomp_r, hurt_r;
    logic [15:0]             score_r;

    logic [10:0]             c_s, r_s;
    logic                    overlap_s, stomp_geom_s, eval_kill_s, eval_hit_s;
    logic                    commit_s, hit_any_s, hurt_s, star_s;
    logic [3:0]              kill_all_s, spawn_s;
    logic [2:0]              kill_cnt_s;
    logic [16:0]             score_add_s, score_sum_s;
    logic [15:0]             score_nxt_s;

`ifdef STAR_MODE_EN
    assign star_s = star;
`else
    assign star_s = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state: ticks are only accepted in IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (tick) begin
                    state_s = ST_SCAN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (idx_r == 2'd3) begin
                    state_s = ST_COMMIT;
                end else begin
                    state_s = ST_SCAN;
                end
            end
            ST_COMMIT: state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // Select the position of the enemy currently being scanned.
    always_comb begin
        c_s = C1;
        r_s = R1;
        case (idx_r)
            2'd0:    begin c_s = C1; r_s = R1; end
            2'd1:    begin c_s = C2; r_s = R2; end
            2'd2:    begin c_s = C3; r_s = R3; end
            2'd3:    begin c_s = C4; r_s = R4; end
            default: begin c_s = C1; r_s = R1; end
        endcase
    end

    // Overlap and stomp classification for the scanned enemy (12-bit sums, no wrap).
    always_comb begin
        overlap_s = mm_r[idx_r]
                  && ({1'b0, mx} < ({1'b0, c_s} + MW12))
                  && ({1'b0, c_s} < ({1'b0, mx} + PW12))
                  && ({1'b0, my} < ({1'b0, r_s} + MH12))
                  && ({1'b0, r_s} < ({1'b0, my} + PH12));
        stomp_geom_s = (({1'b0, my} + PH12) <= ({1'b0, r_s} + TOL12));
        if (star_s) begin
            eval_kill_s = overlap_s;
            eval_hit_s  = 1'b0;
        end else begin
            eval_kill_s = overlap_s && falling && stomp_geom_s;
            eval_hit_s  = overlap_s && !(falling && stomp_geom_s);
        end
    end

    // Commit happens on the last scan step so results appear in the COMMIT cycle.
    always_comb begin
        commit_s    = (state_r == ST_SCAN) && (idx_r == 2'd3);
        kill_all_s  = kill_r | (eval_kill_s ? (4'b0001 << idx_r) : 4'b0000);
        hit_any_s   = hit_r | eval_hit_s;
        kill_cnt_s  = popcount4(kill_all_s);
        score_add_s = 17'(SCORE_STEP) * {14'd0, kill_cnt_s};
        score_sum_s = {1'b0, score_r} + score_add_s;
        if (score_sum_s[16]) begin
            score_nxt_s = 16'hFFFF;
        end else begin
            score_nxt_s = score_sum_s[15:0];
        end
        if (inv_cnt_r != INV_ZERO) begin
            inv_dec_s = inv_cnt_r - INV_ONE;
        end else begin
            inv_dec_s = INV_ZERO;
        end
        // Invincibility is judged on the count after this frame's decrement.
        hurt_s = hit_any_s && (kill_all_s == 4'b0000) && (inv_dec_s == INV_ZERO) && !star_s;
        if (hurt_s) begin
            inv_nxt_s = INV_LOAD;
        end else begin
            inv_nxt_s = inv_dec_s;
        end
    end

    // Per-enemy alive/squash next state; a spawn edge overrides a same-cycle kill.
    always_comb begin
        spawn_s      = MOGU & ~mogu_r;
        mm_nxt_s     = mm_r;
        sq_nxt_s     = sq_r;
        sq_cnt_nxt_s = sq_cnt_r;
        for (int i = 0; i < 4; i++) begin
            if (commit_s) begin
                if (kill_all_s[i]) begin
                    mm_nxt_s[i]     = 1'b0;
                    sq_nxt_s[i]     = 1'b1;
                    sq_cnt_nxt_s[i] = SQ_LOAD;
                end else if (sq_cnt_r[i] != SQ_ZERO) begin
                    sq_cnt_nxt_s[i] = sq_cnt_r[i] - SQ_ONE;
                    if (sq_cnt_r[i] == SQ_ONE) begin
                        sq_nxt_s[i] = 1'b0;
                    end else begin
                        sq_nxt_s[i] = sq_r[i];
                    end
                end else begin
                    sq_cnt_nxt_s[i] = sq_cnt_r[i];
                end
            end else begin
                sq_cnt_nxt_s[i] = sq_cnt_r[i];
            end
            if (spawn_s[i]) begin
                mm_nxt_s[i]     = 1'b1;
                sq_nxt_s[i]     = 1'b0;
                sq_cnt_nxt_s[i] = SQ_ZERO;
            end else begin
                mm_nxt_s[i] = mm_nxt_s[i];
            end
        end
    end

    // Scan bookkeeping: index and per-frame kill/hit flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r  <= 2'd0;
            kill_r <= 4'b0000;
            hit_r  <= 1'b0;
        end else if (state_r == ST_SCAN) begin
            idx_r  <= idx_r + 2'd1;
            kill_r <= kill_all_s;
            hit_r  <= hit_any_s;
        end else begin
            idx_r  <= 2'd0;
            kill_r <= 4'b0000;
            hit_r  <= 1'b0;
        end
    end

    // Enemy state, score, invincibility and event pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mogu_r    <= 4'b0000;
            mm_r      <= 4'b0000;
            sq_r      <= 4'b0000;
            sq_cnt_r  <= {4{SQ_ZERO}};
            inv_cnt_r <= INV_ZERO;
            inv_r     <= 1'b0;
            stomp_r   <= 1'b0;
            hurt_r    <= 1'b0;
            score_r   <= 16'h0000;
        end else begin
            mogu_r   <= MOGU;
            mm_r     <= mm_nxt_s;
            sq_r     <= sq_nxt_s;
            sq_cnt_r <= sq_cnt_nxt_s;
            stomp_r  <= commit_s && (kill_all_s != 4'b0000);
            hurt_r   <= commit_s && hurt_s;
            if (commit_s) begin
                inv_cnt_r <= inv_nxt_s;
                inv_r     <= (inv_nxt_s != INV_ZERO);
                score_r   <= score_nxt_s;
            end else begin
                inv_cnt_r <= inv_cnt_r;
                inv_r     <= inv_r;
                score_r   <= score_r;
            end
        end
    end

    assign MM    = mm_r;
    assign SQ    = sq_r;
    assign stomp = stomp_r;
    assign hurt  = hurt_r;
    assign inv   = inv_r;
    assign score = score_r;

endmodule

// File: tb/tb_mogu_collide.sv
// Directed self-checking bench for mogu_collide.
module tb_mogu_collide;

    logic        clk = 1'b0;
    logic        rst_n, tick, falling;
    logic [3:0]  MOGU;
    logic [10:0] C1, C2, C3, C4, R1, R2, R3, R4, mx, my;
    logic [3:0]  MM, SQ;
    logic        stomp, hurt, inv;
    logic [15:0] score;
`ifdef STAR_MODE_EN
    logic        star = 1'b0;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int pulses;

    mogu_collide dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .MOGU(MOGU),
        .C1(C1), .C2(C2), .C3(C3), .C4(C4),
        .R1(R1), .R2(R2), .R3(R3), .R4(R4),
        .mx(mx), .my(my), .falling(falling),
`ifdef STAR_MODE_EN
        .star(star),
`endif
        .MM(MM), .SQ(SQ), .stomp(stomp), .hurt(hurt), .inv(inv), .score(score)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Tick in an idle cycle, then stop in the COMMIT cycle (T+5).
    task automatic run_frame();
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Drop then raise the given MOGU bits to produce spawn edges.
    task automatic respawn(input logic [3:0] keep, input logic [3:0] bits);
        @(negedge clk);
        MOGU = keep;
        @(negedge clk);
        MOGU = keep | bits;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; tick = 1'b0; falling = 1'b0; MOGU = 4'b0000;
        C1 = 11'd100; R1 = 11'd144; C2 = 11'd1000; R2 = 11'd1000;
        C3 = 11'd1000; R3 = 11'd1000; C4 = 11'd1000; R4 = 11'd1000;
        mx = 11'd600; my = 11'd600;
        repeat (2) @(negedge clk);
        check("rst_MM", 32'(MM), 32'h0);
        check("rst_SQ", 32'(SQ), 32'h0);
        check("rst_score", 32'(score), 32'h0);
        check("rst_pulses", {29'd0, stomp, hurt, inv}, 32'h0);
        rst_n = 1'b1;

        // Spawn enemy 0.
        @(negedge clk);
        MOGU = 4'b0001;
        @(negedge clk);
        check("spawn_MM", 32'(MM), 32'h1);
        check("spawn_SQ", 32'(SQ), 32'h0);
        check("spawn_score", 32'(score), 32'h0);

        // Stomp enemy 0.
        mx = 11'd104; my = 11'd130; falling = 1'b1;
        run_frame();
        check("stomp_MM", 32'(MM), 32'h0);
        check("stomp_SQ", 32'(SQ), 32'h1);
        check("stomp_pulse", 32'(stomp), 32'h1);
        check("stomp_nohurt", 32'(hurt), 32'h0);
        check("stomp_score", 32'(score), 32'd100);
        @(negedge clk);
        check("stomp_oneclk", 32'(stomp), 32'h0);
        mx = 11'd600; my = 11'd600;
        repeat (7) run_frame();
        check("squash_hold7", 32'(SQ), 32'h1);
        run_frame();
        check("squash_clear8", 32'(SQ), 32'h0);

        // Side hit and invincibility window.
        respawn(4'b0000, 4'b0001);
        check("respawn_MM", 32'(MM), 32'h1);
        mx = 11'd90; my = 11'd144; falling = 1'b0;
        run_frame();
        check("hit_hurt", 32'(hurt), 32'h1);
        check("hit_inv", 32'(inv), 32'h1);
        check("hit_MM", 32'(MM), 32'h1);
        check("hit_nostomp", 32'(stomp), 32'h0);
        pulses = 0;
        for (int k = 0; k < 59; k++) begin
            run_frame();
            if (hurt === 1'b1) pulses++;
        end
        check("inv_window_nohurt", 32'(pulses), 32'd0);
        check("inv_window_inv", 32'(inv), 32'h1);
        run_frame();
        check("inv_expired_hurt", 32'(hurt), 32'h1);
        mx = 11'd600; my = 11'd600;
        repeat (59) run_frame();
        check("inv_hold59", 32'(inv), 32'h1);
        run_frame();
        check("inv_clear60", 32'(inv), 32'h0);

        // Mixed frame: enemy 0 stomped, enemy 1 side-overlapping.
        C2 = 11'd112; R2 = 11'd132;
        respawn(4'b0000, 4'b0011);
        check("mixed_pre_MM", 32'(MM), 32'h3);
        mx = 11'd104; my = 11'd130; falling = 1'b1;
        run_frame();
        check("mixed_stomp", 32'(stomp), 32'h1);
        check("mixed_nohurt", 32'(hurt), 32'h0);
        check("mixed_score", 32'(score), 32'd200);
        check("mixed_MM", 32'(MM), 32'h2);
        check("mixed_SQ", 32'(SQ), 32'h1);

        // Double stomp.
        C2 = 11'd110; R2 = 11'd144;
        respawn(4'b0010, 4'b0001);
        run_frame();
        check("double_MM", 32'(MM), 32'h0);
        check("double_SQ", 32'(SQ), 32'h3);
        check("double_score", 32'(score), 32'd400);

        // Drive score up to saturation with repeated double stomps.
        for (int k = 0; k < 325; k++) begin
            respawn(4'b0000, 4'b0011);
            run_frame();
        end
        check("presat_score", 32'(score), 32'h0000FF78);
        respawn(4'b0000, 4'b0011);
        run_frame();
        check("sat_score", 32'(score), 32'h0000FFFF);
        check("sat_stomp", 32'(stomp), 32'h1);

        // Repeated tick at T+2 is ignored: exactly one commit.
        respawn(4'b0000, 4'b0001);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            if (k == 1) tick = 1'b1;
            if (k == 2) tick = 1'b0;
            if (stomp === 1'b1) pulses++;
            @(negedge clk);
        end
        check("retick_one_commit", 32'(pulses), 32'd1);
        check("retick_MM", 32'(MM), 32'h0);

        // Reset in the middle of a scan.
        respawn(4'b0000, 4'b0001);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_MM", 32'(MM), 32'h0);
        check("midrst_SQ", 32'(SQ), 32'h0);
        check("midrst_score", 32'(score), 32'h0);
        check("midrst_flags", {29'd0, stomp, hurt, inv}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (stomp === 1'b1 || hurt === 1'b1) pulses++;
        end
        check("midrst_nopulse", 32'(pulses), 32'd0);
        check("midrst_score_after", 32'(score), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
